// File: rtl/attempt_verifier.sv
`default_nettype none
// ============================================================================
// Module   : attempt_verifier
// Brief    : Compares a confirmed BCD code against the stored code, issues
//            pass/fail pulses, counts failures, enforces back-off and alarm.
// Revision : 1.0 - initial release
// ============================================================================
module attempt_verifier #(
    parameter int DIGITS      = 4,
    parameter int MAX_ERRORS  = 3,
    parameter int LOCK_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  ok_pulse,
    input  logic                  admin_clear,
    input  logic                  entry_complete,
    input  logic [4*DIGITS-1:0]   entered,
    input  logic [4*DIGITS-1:0]   stored,
    output logic                  pass_pulse,
    output logic                  fail_pulse,
    output logic [1:0]            error_count,
    output logic                  alarm,
    output logic                  busy
);

    localparam int c_CODE_W = 4 * DIGITS;
    localparam int c_CNT_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(LOCK_CYCLES - 1);
    localparam logic [1:0]         c_MAX  = 2'(MAX_ERRORS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_ALARM   = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CODE_W-1:0]  r_shadow;
    logic                 r_shadow_complete;
    logic [c_CNT_W-1:0]   r_backoff;

    logic [DIGITS-1:0]    w_digit_ok;
    logic                 w_match;
    logic [1:0]           w_next_count;

    // A code with any non-BCD nibble can never match, even if stored holds it.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_digit_ok[i] = (r_shadow[4*i +: 4] <= 4'd9);
    end

    assign w_match      = r_shadow_complete && (&w_digit_ok) && (r_shadow == stored);
    assign w_next_count = (error_count >= c_MAX) ? c_MAX : error_count + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_shadow          <= '0;
            r_shadow_complete <= 1'b0;
            r_backoff         <= '0;
            pass_pulse        <= 1'b0;
            fail_pulse        <= 1'b0;
            error_count       <= 2'd0;
            alarm             <= 1'b0;
            busy              <= 1'b0;
        end else begin
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            if (admin_clear) begin
                r_state     <= ST_IDLE;
                r_backoff   <= '0;
                error_count <= 2'd0;
                alarm       <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ok_pulse && enable) begin
                            r_shadow          <= entered;
                            r_shadow_complete <= entry_complete;
                            r_state           <= ST_CHECK;
                            busy              <= 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        // Leaving the editing state abandons the attempt silently.
                        if (!enable) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else if (w_match) begin
                            pass_pulse  <= 1'b1;
                            error_count <= 2'd0;
                            r_state     <= ST_IDLE;
                            busy        <= 1'b0;
                        end else begin
                            fail_pulse  <= 1'b1;
                            error_count <= w_next_count;
                            if (w_next_count == c_MAX) begin
                                alarm   <= 1'b1;
                                r_state <= ST_ALARM;
                            end else begin
                                r_backoff <= c_LOAD;
                                r_state   <= ST_BACKOFF;
                            end
                        end
                    end
                    ST_BACKOFF: begin
                        if (r_backoff == '0) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_backoff <= r_backoff - 1'b1;
                        end
                    end
                    ST_ALARM: begin
                        alarm <= 1'b1;
                        busy  <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_attempt_verifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_attempt_verifier
// Brief    : Scoreboard bench for attempt_verifier (LOCK_CYCLES=4, MAX_ERRORS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_attempt_verifier;

    localparam int c_NONE = 0;
    localparam int c_PASS = 1;
    localparam int c_FAIL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        ok_pulse = 1'b0;
    logic        admin_clear = 1'b0;
    logic        entry_complete = 1'b1;
    logic [15:0] entered = 16'h0000;
    logic [15:0] stored = 16'h1234;
    logic        pass_pulse;
    logic        fail_pulse;
    logic [1:0]  error_count;
    logic        alarm;
    logic        busy;

    attempt_verifier #(
        .DIGITS      (4),
        .MAX_ERRORS  (3),
        .LOCK_CYCLES (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .ok_pulse       (ok_pulse),
        .admin_clear    (admin_clear),
        .entry_complete (entry_complete),
        .entered        (entered),
        .stored         (stored),
        .pass_pulse     (pass_pulse),
        .fail_pulse     (fail_pulse),
        .error_count    (error_count),
        .alarm          (alarm),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cnt;
        int alm;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Every pulse must correspond to the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (pass_pulse || fail_pulse) begin
            chk("pulse_exclusive", {31'd0, pass_pulse & fail_pulse}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, fail_pulse, pass_pulse}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", (pass_pulse ? c_PASS : c_FAIL), e.kind);
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_count", {30'd0, error_count}, e.cnt);
                chk("pulse_alarm", {31'd0, alarm}, e.alm);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one confirm pulse; the verdict appears two edges after the drive point.
    task automatic confirm(input logic [15:0] code, input logic complete,
                           input int kind, input int cnt, input int alm);
        entered        = code;
        entry_complete = complete;
        ok_pulse       = 1'b1;
        if (kind != c_NONE) sb.push_back('{kind, cnt, alm, cyc + 2});
        step();
        ok_pulse       = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) step();
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic admin();
        admin_clear = 1'b1;
        step();
        admin_clear = 1'b0;
    endtask

    initial begin
        // Reset
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {30'd0, error_count}, 32'd0);
        chk("rst_alarm", {31'd0, alarm}, 32'd0);
        chk("rst_pulses", {30'd0, pass_pulse, fail_pulse}, 32'd0);
        rst = 1'b0;
        step();
        step();

        // Test 1: correct code, entered altered during CHECK is ignored
        confirm(16'h1234, 1'b1, c_PASS, 0, 0);
        chk("t1_busy_check", {31'd0, busy}, 32'd1);
        entered = 16'h9999;
        step();
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        chk("t1_count", {30'd0, error_count}, 32'd0);
        step();
        chk("t1_pass_single", {31'd0, pass_pulse}, 32'd0);

        // Test 2: wrong code, back-off dwell and ignored confirm
        confirm(16'h1235, 1'b1, c_FAIL, 1, 0);
        chk("t2_busy_a", {31'd0, busy}, 32'd1);
        step();
        chk("t2_busy_b", {31'd0, busy}, 32'd1);
        ok_pulse = 1'b1;
        step();
        ok_pulse = 1'b0;
        chk("t2_busy_c", {31'd0, busy}, 32'd1);
        step();
        chk("t2_busy_d", {31'd0, busy}, 32'd1);
        step();
        chk("t2_busy_e", {31'd0, busy}, 32'd1);
        step();
        chk("t2_busy_end", {31'd0, busy}, 32'd0);
        confirm(16'h1234, 1'b1, c_PASS, 0, 0);
        chk("t2_accept", {31'd0, busy}, 32'd1);
        wait_idle();

        // Test 3: three failures raise the alarm; only admin clears it
        confirm(16'h0000, 1'b1, c_FAIL, 1, 0);
        wait_idle();
        confirm(16'h0001, 1'b1, c_FAIL, 2, 0);
        wait_idle();
        confirm(16'h0002, 1'b1, c_FAIL, 3, 1);
        step();
        step();
        chk("t3_alarm", {31'd0, alarm}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        confirm(16'h1234, 1'b1, c_NONE, 0, 0);
        step();
        step();
        chk("t3_alarm_hold", {31'd0, alarm}, 32'd1);
        chk("t3_count_sat", {30'd0, error_count}, 32'd3);
        admin();
        chk("t3_clr_alarm", {31'd0, alarm}, 32'd0);
        chk("t3_clr_count", {30'd0, error_count}, 32'd0);
        chk("t3_clr_busy", {31'd0, busy}, 32'd0);

        // Test 4: pass resets the consecutive-failure count
        confirm(16'h4321, 1'b1, c_FAIL, 1, 0);
        wait_idle();
        confirm(16'h4321, 1'b1, c_FAIL, 2, 0);
        wait_idle();
        confirm(16'h1234, 1'b1, c_PASS, 0, 0);
        wait_idle();
        chk("t4_count_zero", {30'd0, error_count}, 32'd0);
        confirm(16'h1111, 1'b1, c_FAIL, 1, 0);
        wait_idle();
        chk("t4_no_alarm", {31'd0, alarm}, 32'd0);
        admin();

        // Test 5: incomplete entry and non-BCD digits are rejected
        confirm(16'h1234, 1'b0, c_FAIL, 1, 0);
        wait_idle();
        stored = 16'h12A4;
        confirm(16'h12A4, 1'b1, c_FAIL, 2, 0);
        wait_idle();
        admin();
        stored = 16'h1234;

        // Test 6a: admin_clear during CHECK suppresses the verdict
        confirm(16'h5555, 1'b1, c_FAIL, 1, 0);
        wait_idle();
        confirm(16'h5555, 1'b1, c_NONE, 0, 0);
        admin();
        chk("t6_admin_busy", {31'd0, busy}, 32'd0);
        chk("t6_admin_count", {30'd0, error_count}, 32'd0);
        step();
        step();

        // Test 6b: enable drop during CHECK aborts without changing the count
        confirm(16'h5555, 1'b1, c_FAIL, 1, 0);
        wait_idle();
        confirm(16'h5555, 1'b1, c_NONE, 0, 0);
        enable = 1'b0;
        step();
        enable = 1'b1;
        chk("t6_abort_busy", {31'd0, busy}, 32'd0);
        chk("t6_abort_count", {30'd0, error_count}, 32'd1);
        step();

        // Test 6c: reset during BACKOFF
        confirm(16'h5555, 1'b1, c_FAIL, 2, 0);
        step();
        step();
        chk("t6_in_backoff", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_count", {30'd0, error_count}, 32'd0);
        chk("t6_rst_alarm", {31'd0, alarm}, 32'd0);
        step();
        chk("t6_rst_stay_idle", {31'd0, busy}, 32'd0);

        step();
        step();
        chk("sb_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
